alu_arbiter: RTL and testbench

Shares the single 8-bit CPU ALU between up to N_REQ requesters (CPU execute stage, sprite/blitter unit, etc.) using round-robin arbitration with optional lock for multi-op sequences. Sits between the requesters and the combinational `alu` instance: drives its operation, operand-select and data inputs, registers its result and returns it to the winning requester one cycle after acceptance.

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with optional per-requester lock
module alu_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_lock,
  input  logic [3*N_REQ-1:0]   req_op,
  input  logic [N_REQ-1:0]     req_operand,
  input  logic [8*N_REQ-1:0]   req_r0,
  input  logic [8*N_REQ-1:0]   req_rx,
  input  logic [8*N_REQ-1:0]   req_imm,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [2:0]           alu_operation,
  output logic                 alu_operand,
  output logic [7:0]           alu_r0,
  output logic [7:0]           alu_rx,
  output logic [7:0]           alu_imm,
  input  logic [7:0]           alu_result,
  output logic [1:0]           lock_owner,
  output logic                 locked
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d, rr_q, rr_d, gi;
  logic [7:0]       cnt_q, cnt_d, rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d, gnt;
  logic             any;
  logic [3:0]       v_p, l_p, o_p;
  logic [11:0]      op_p;
  logic [31:0]      r0_p, rx_p, imm_p;
  assign v_p   = 4'(req_valid);
  assign l_p   = 4'(req_lock);
  assign o_p   = 4'(req_operand);
  assign op_p  = 12'(req_op);
  assign r0_p  = 32'(req_r0);
  assign rx_p  = 32'(req_rx);
  assign imm_p = 32'(req_imm);
  // winner: the lock owner alone while locked, otherwise first valid requester after rr_q
  always_comb begin
    any = 1'b0;
    gi  = '0;
    if (state_q == LOCKED) begin
      any = v_p[owner_q];
      gi  = owner_q;
    end else begin
      for (int k = 1; k <= N_REQ; k++)
        if (!any && v_p[2'((int'(rr_q) + k) % N_REQ)]) begin
          any = 1'b1;
          gi  = 2'((int'(rr_q) + k) % N_REQ);
        end
    end
    gnt = any ? N_REQ'(1 << gi) : '0;
  end
  assign req_ready     = gnt;
  assign alu_operation = any ? op_p[3*gi +: 3] : 3'd0;
  assign alu_operand   = any ? o_p[gi] : 1'b0;
  assign alu_r0        = any ? r0_p[8*gi +: 8] : 8'd0;
  assign alu_rx        = any ? rx_p[8*gi +: 8] : 8'd0;
  assign alu_imm       = any ? imm_p[8*gi +: 8] : 8'd0;
  // capture the result of an accepted op and move the lock state machine
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    rsp_data_d  = any ? alu_result : rsp_data_q;
    rsp_valid_d = gnt;
    if (any) rr_d = gi;
    if (state_q == IDLE) begin
      if (any && l_p[gi]) begin
        state_d = LOCKED;
        owner_d = gi;
        cnt_d   = '0;
      end
    end else if (any) begin
      cnt_d = '0;
      if (!l_p[gi]) state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(LOCK_TIMEOUT)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end
  // state registers; rr_q starts on the last requester so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= 2'(N_REQ - 1);
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign lock_owner = owner_q;
  assign locked     = state_q == LOCKED;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  localparam int N  = 2;
  localparam int LT = 15;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_lock, req_operand, rsp_valid;
  logic [3*N-1:0]  req_op;
  logic [8*N-1:0]  req_r0, req_rx, req_imm;
  logic [7:0]      rsp_data, alu_r0, alu_rx, alu_imm, alu_result;
  logic [2:0]      alu_operation;
  logic            alu_operand, locked;
  logic [1:0]      lock_owner;
  int passed = 0, total = 0;
  int m_locked, m_owner, m_last, m_idle, m_rv, m_rd;
  logic [N-1:0] last_ready;
  int n;

  alu_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_op(req_op), .req_operand(req_operand),
    .req_r0(req_r0), .req_rx(req_rx), .req_imm(req_imm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .alu_operation(alu_operation), .alu_operand(alu_operand),
    .alu_r0(alu_r0), .alu_rx(alu_rx), .alu_imm(alu_imm), .alu_result(alu_result),
    .lock_owner(lock_owner), .locked(locked));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a * b;
      3'd6: return a >> b;
      default: return a << b;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_operation, alu_r0, alu_operand ? alu_imm : alu_rx);

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic int mgrant();
    if (m_locked != 0) return bit_of(req_valid, m_owner) ? m_owner : -1;
    for (int k = 1; k <= N; k++)
      if (bit_of(req_valid, (m_last + k) % N)) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mreset();
    m_locked = 0; m_owner = 0; m_last = N - 1; m_idle = 0; m_rv = 0; m_rd = 0;
  endtask

  task automatic setr(input int i, input bit v, input bit lk, input logic [2:0] op,
                      input bit opd, input logic [7:0] r0, input logic [7:0] rx, input logic [7:0] imm);
    req_valid[i] = v; req_lock[i] = lk; req_operand[i] = opd;
    req_op[3*i +: 3] = op; req_r0[8*i +: 8] = r0; req_rx[8*i +: 8] = rx; req_imm[8*i +: 8] = imm;
  endtask

  task automatic clr();
    req_valid = '0; req_lock = '0; req_operand = '0; req_op = '0;
    req_r0 = '0; req_rx = '0; req_imm = '0;
  endtask

  task automatic cyc();
    int g;
    logic [7:0] a, b, op;
    #2;
    g = mgrant();
    last_ready = req_ready;
    chk("ready", req_ready, g < 0 ? 0 : (1 << g));
    if (g >= 0) begin
      op = 8'(req_op >> (3*g)) & 8'h7;
      a  = 8'(req_r0 >> (8*g));
      b  = bit_of(req_operand, g) ? 8'(req_imm >> (8*g)) : 8'(req_rx >> (8*g));
      chk("alu_in", {alu_operation, alu_r0, alu_operand ? alu_imm : alu_rx}, {op[2:0], a, b});
      m_rv = 1 << g; m_rd = ref_alu(op[2:0], a, b); m_last = g;
      if (m_locked == 0) begin
        if (bit_of(req_lock, g)) begin m_locked = 1; m_owner = g; m_idle = 0; end
      end else begin
        m_idle = 0;
        if (!bit_of(req_lock, g)) m_locked = 0;
      end
    end else begin
      chk("alu_idle", {alu_operation, alu_operand, alu_r0, alu_rx, alu_imm}, 0);
      m_rv = 0;
      if (m_locked != 0) begin
        m_idle++;
        if (m_idle == LT) begin m_locked = 0; m_idle = 0; end
      end
    end
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_data", rsp_data, m_rd);
    chk("locked", locked, m_locked);
    if (m_locked != 0) chk("lock_owner", lock_owner, m_owner);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    mreset();
    #3;
    chk("reset_outs", {rsp_valid, rsp_data, locked, lock_owner, req_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    setr(0, 1, 0, 3'd0, 0, 8'h10, 8'h05, 8'h00);
    cyc();
    chk("add_rsp", {rsp_valid, rsp_data}, {2'b01, 8'h15});
    clr();
    setr(0, 1, 0, 3'd1, 0, 8'h05, 8'h07, 8'h00);
    setr(1, 1, 0, 3'd4, 1, 8'hF0, 8'h00, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt_data", rsp_data, (i % 2 == 0) ? 8'hFF : 8'hFE);
    end
    setr(0, 1, 0, 3'd0, 0, 8'h01, 8'h01, 8'h00);
    setr(1, 1, 1, 3'd5, 1, 8'h20, 8'h00, 8'h10);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lock_grant", {last_ready, rsp_data, locked}, {2'b10, 8'h00, 1'b1});
    end
    setr(1, 1, 0, 3'd5, 1, 8'h20, 8'h00, 8'h10);
    cyc();
    chk("unlock", locked, 1'b0);
    cyc();
    chk("after_unlock", last_ready, 2'b01);
    clr();
    setr(0, 1, 1, 3'd2, 0, 8'h3C, 8'h0F, 8'h00);
    cyc();
    chk("lock0", {locked, lock_owner}, {1'b1, 2'd0});
    clr();
    setr(1, 1, 0, 3'd3, 0, 8'h01, 8'h02, 8'h00);
    n = 0;
    do begin cyc(); n++; end while (!last_ready[1] && n < 40);
    chk("timeout_wait", n, LT + 1);
    chk("timeout_unlocked", locked, 1'b0);
    clr();
    setr(0, 1, 0, 3'd7, 1, 8'h01, 8'h00, 8'h08);
    cyc();
    chk("sl8", rsp_data, 8'h00);
    setr(0, 1, 0, 3'd6, 0, 8'h80, 8'h07, 8'h00);
    cyc();
    chk("sr7", rsp_data, 8'h01);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) != 0 || !bit_of(req_valid, i) || bit_of(last_ready, i))
          setr(i, $urandom_range(1) == 1, $urandom_range(3) == 0, 3'($urandom_range(7)),
               $urandom_range(1) == 1, 8'($urandom), 8'($urandom_range(9)), 8'($urandom_range(9)));
      cyc();
    end
    clr();
    for (int i = 0; i < LT + 2; i++) cyc();
    setr(1, 1, 1, 3'd0, 0, 8'h11, 8'h22, 8'h00);
    cyc();
    chk("pre_reset_lock", {locked, rsp_valid}, {1'b1, 2'b10});
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {rsp_valid, locked, rsp_data}, 0);
    mreset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    setr(0, 1, 0, 3'd0, 0, 8'h01, 8'h02, 8'h00);
    setr(1, 1, 0, 3'd0, 0, 8'h03, 8'h04, 8'h00);
    cyc();
    chk("post_reset_first", last_ready, 2'b01);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
